seg_scan6: RTL and testbench

Six-digit multiplexed 7-segment display driver for the stopwatch/clock path. Sits directly downstream of the BCD counter chain (hundredths, tenths, seconds, tens-of-seconds, minutes, tens-of-minutes). Takes a snapshot of all six BCD digits once per scan frame so a carry ripple never tears the displayed value. Drives one active-low anode at a time with its decoded active-low segment pattern.

---
 rtl/seg_scan_pkg.sv | 10 +
 rtl/bcd_to_seg7.sv | 8 +
 rtl/seg_scan6.sv | 74 +++++++
 tb/tb_seg_scan6.sv | 124 ++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants for the six-digit multiplexed 7-segment scanner.
package seg_scan_pkg;
    localparam int NUM_DIGITS = 6;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    // Active-low {g,f,e,d,c,b,a} patterns, digit 9 in the top slot down to digit 0
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD nibble to active-low 7-segment pattern; nibbles 10-15 show a dash.
module bcd_to_seg7 (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    import seg_scan_pkg::*;
    assign seg_o = (nib_i > 4'd9) ? SEG_DASH : SEG_DIGITS[nib_i];
endmodule

// File: rtl/seg_scan6.sv
// seg_scan6: six-digit multiplexed 7-segment driver with per-frame snapshot of the BCD digits.
// Define SEG_SCAN_LZB_EN to blank leading zeros on digits 5..3.
module seg_scan6
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV = 1
) (
    input  logic        clk1khz,
    input  logic        rst,
    input  logic        en,
    input  logic        hold,
    input  logic [23:0] digits_in,
    input  logic [5:0]  dp_mask,
    output logic [5:0]  an,
    output logic [7:0]  seg
);
    logic [7:0]  pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic [5:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        tick, wrap, blank;
    logic [3:0]  nib;
    logic [6:0]  seg7;

    assign tick = en && (pre_q == 8'(SCAN_DIV - 1));
    assign wrap = idx_q == 3'(NUM_DIGITS - 1);
    assign nib  = snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .nib_i(nib),
        .seg_o(seg7)
    );

`ifdef SEG_SCAN_LZB_EN
    logic z5, z4, z3;
    logic [7:0] lz;
    // lz[i] set when snap digits 5..i are all zero; only digits 5..3 may blank
    assign z5 = snap_q[23:20] == 4'd0;
    assign z4 = z5 && snap_q[19:16] == 4'd0;
    assign z3 = z4 && snap_q[15:12] == 4'd0;
    assign lz = {2'b00, z5, z4, z3, 3'b000};
    assign blank = lz[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        pre_d  = tick ? 8'd0 : (en ? pre_q + 8'd1 : pre_q);
        idx_d  = tick ? (wrap ? 3'd0 : idx_q + 3'd1) : idx_q;
        snap_d = (tick && wrap && !hold) ? digits_in : snap_q;
        an_d   = en ? ~(6'd1 << idx_q) : 6'h3F;
        seg_d  = en ? {~dp_mask[idx_q], blank ? SEG_BLANK : seg7} : 8'hFF;
    end

    always_ff @(posedge clk1khz or negedge rst) begin
        if (!rst) begin
            pre_q  <= 8'd0;
            idx_q  <= 3'd0;
            snap_q <= 24'd0;
            an_q   <= 6'h3F;
            seg_q  <= 8'hFF;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
endmodule

// File: tb/tb_seg_scan6.sv
// tb_seg_scan6: scoreboard bench driving SCAN_DIV=1 and SCAN_DIV=4 instances from one stimulus stream.
module tb_seg_scan6;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        hold = 1'b0;
    logic [23:0] digits_in = 24'd0;
    logic [5:0]  dp_mask = 6'd0;
    logic [5:0]  an1, an4;
    logic [7:0]  seg1, seg4;
    int          total = 0;
    int          bad = 0;
    logic [13:0] q1[$];
    logic [13:0] q4[$];
    int          n[2];
    logic [23:0] snap[2];
    localparam logic [7:0] PAT[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    seg_scan6 #(.SCAN_DIV(1)) dut1 (
        .clk1khz(clk), .rst(rst), .en(en), .hold(hold),
        .digits_in(digits_in), .dp_mask(dp_mask), .an(an1), .seg(seg1)
    );

    seg_scan6 #(.SCAN_DIV(4)) dut4 (
        .clk1khz(clk), .rst(rst), .en(en), .hold(hold),
        .digits_in(digits_in), .dp_mask(dp_mask), .an(an4), .seg(seg4)
    );

    function automatic logic [6:0] glyph(logic [23:0] s, int i);
        logic [3:0] d;
        logic [7:0] p;
        d = s[i*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
        if (i >= 3 && (s >> (i*4)) == 24'd0) return 7'h7F;
`endif
        if (d > 4'd9) return 7'h3F;
        p = PAT[d];
        return p[6:0];
    endfunction

    // Display position follows from the count of enabled cycles since reset
    task automatic model_step(input int k, output logic [13:0] e);
        int div;
        int idx;
        div = (k == 0) ? 1 : 4;
        if (!rst) begin
            n[k] = 0;
            snap[k] = 24'd0;
            e = {6'h3F, 8'hFF};
        end else if (!en) begin
            e = {6'h3F, 8'hFF};
        end else begin
            idx = (n[k] / div) % 6;
            e = {~(6'b1 << idx), ~dp_mask[idx], glyph(snap[k], idx)};
            n[k]++;
            if (n[k] % (6 * div) == 0 && !hold) snap[k] = digits_in;
        end
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got an=%h seg=%h, want an=%h seg=%h",
                     name, $time, act[13:8], act[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic step(input logic r, input logic e_in, input logic h,
                        input logic [23:0] d, input logic [5:0] m);
        logic [13:0] x;
        @(negedge clk);
        rst = r;
        en = e_in;
        hold = h;
        digits_in = d;
        dp_mask = m;
        model_step(0, x);
        q1.push_back(x);
        model_step(1, x);
        q4.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) check("div1", {an1, seg1}, q1.pop_front());
        if (q4.size() > 0) check("div4", {an4, seg4}, q4.pop_front());
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("reset_div1", {an1, seg1}, {6'h3F, 8'hFF});
        check("reset_div4", {an4, seg4}, {6'h3F, 8'hFF});
        repeat (3) step(1'b0, 1'b1, 1'b0, 24'h123456, 6'd0);
        repeat (60) step(1'b1, 1'b1, 1'b0, 24'h123456, 6'd0);
        repeat (150) step(1'b1, 1'b1, 1'b0, 24'($urandom), 6'($urandom));
        repeat (60) step(1'b1, 1'b1, 1'b1, 24'($urandom), 6'($urandom));
        repeat (60) step(1'b1, 1'b1, 1'b0, 24'h987654, 6'($urandom));
        repeat (13) step(1'b1, 1'b1, 1'b0, 24'h111111, 6'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 24'h222222, 6'd0);
        repeat (30) step(1'b1, 1'b1, 1'b0, 24'h333333, 6'd0);
        repeat (60) step(1'b1, 1'b1, 1'b0, 24'h000C00, 6'b000100);
        repeat (250) step(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                          24'($urandom), 6'($urandom));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_div1", {an1, seg1}, {6'h3F, 8'hFF});
        check("async_rst_div4", {an4, seg4}, {6'h3F, 8'hFF});
        repeat (2) step(1'b0, 1'b1, 1'b0, 24'h000905, 6'd0);
        repeat (60) step(1'b1, 1'b1, 1'b0, 24'h000905, 6'd0);
        repeat (60) step(1'b1, 1'b1, 1'b0, 24'h000000, 6'b000100);
        repeat (200) step(1'b1, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
                          24'($urandom) & 24'h0F0F0F, 6'($urandom));
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
